// File: rtl/sobel_stream_engine.sv
// ---------------------------------------------------------------------------
// sobel_stream_engine
//
// Streaming 3x3 Sobel edge engine. The input image is read once in raster
// order (one address per clock); two previous image rows are kept in a line
// buffer, so one output pixel is produced per clock and each output address
// is written exactly once.
//
// Optional build macro: SOBEL_STATS_EN
//   When defined, adds the edge_count output. This output counts interior
//   pixels that are written as edges (value 0) in threshold mode.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      1-cycle pulse, starts a frame when idle
//   mode       sampled at start: 0 = binary threshold, 1 = saturated magnitude
//   threshold  edge threshold (PIX_W+3 bits), sampled at start
//   rd_addr    input BRAM read address (raster order)
//   rd_data    input BRAM data, valid RD_LAT clocks after rd_addr
//   wr_en      output BRAM write enable
//   wr_addr    output BRAM write address
//   wr_data    output BRAM write data
//   busy       high while a frame is in progress
//   done       1-cycle pulse after the last write
//   edge_count (SOBEL_STATS_EN only) edge pixels of the last/current frame
// ---------------------------------------------------------------------------
module sobel_stream_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [PIX_W+2:0]  threshold,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done
`ifdef SOBEL_STATS_EN
  ,
  output logic [ADDR_W:0]   edge_count
`endif
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  // The first window whose bottom-right pixel is on rd_data appears in
  // cycle IMG_W+RD_LAT+2; its result is registered at the end of that cycle.
  localparam int LEAD_SET = IMG_W + RD_LAT + 1;
  localparam int LW = $clog2(LEAD_SET + 2) + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [LW-1:0]     LEAD_ARM  = LW'(LEAD_SET);
  localparam logic [LW-1:0]     LEAD_STOP = LW'(LEAD_SET + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] rd_addr_reg;
  logic [CW-1:0]     rd_col_reg;     // column of rd_addr_reg
  logic [CW-1:0]     lb_wcol_reg;    // column of the pixel now on rd_data
  logic              rd_vld_reg;     // rd_data carries a frame pixel
  logic [LW-1:0]     lead_reg;       // cycles since start acceptance (saturating)
  logic              out_run_reg;    // an output pixel is computed this cycle
  logic [ADDR_W-1:0] out_cnt_reg;
  logic [CW-1:0]     out_col_reg;
  logic [RW-1:0]     out_row_reg;
  logic              mode_reg;
  logic [GW-1:0]     thr_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [PIX_W-1:0]  wr_data_reg;

  logic              accept;
  logic [PIX_W-1:0]  pix_out;
  logic              border;
  logic              edge_hit;

  assign accept = (state_reg == ST_IDLE) && start;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SCAN;
      ST_SCAN:  if (rd_addr_reg == LAST_ADDR) state_next = ST_DRAIN;
      ST_DRAIN: if (wr_en_reg && (wr_addr_reg == LAST_ADDR)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg == ST_SCAN) || (state_reg == ST_DRAIN);
  assign done = (state_reg == ST_DONE);

  // ---------------- Read, sequencing and output registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_reg <= '0;
      rd_col_reg  <= '0;
      lb_wcol_reg <= '0;
      rd_vld_reg  <= 1'b0;
      lead_reg    <= '0;
      out_run_reg <= 1'b0;
      out_cnt_reg <= '0;
      out_col_reg <= '0;
      out_row_reg <= '0;
      mode_reg    <= 1'b0;
      thr_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      rd_vld_reg  <= (state_reg == ST_SCAN);
      lb_wcol_reg <= rd_col_reg;
      wr_en_reg   <= out_run_reg;
      if (out_run_reg) begin
        wr_addr_reg <= out_cnt_reg;
        wr_data_reg <= pix_out;
      end

      if (accept) begin
        mode_reg    <= mode;
        thr_reg     <= threshold;
        rd_addr_reg <= '0;
        rd_col_reg  <= '0;
        lead_reg    <= LW'(1);
        out_run_reg <= 1'b0;
        out_cnt_reg <= '0;
        out_col_reg <= '0;
        out_row_reg <= '0;
      end else begin
        if ((state_reg == ST_SCAN) && (rd_addr_reg != LAST_ADDR)) begin
          rd_addr_reg <= rd_addr_reg + 1'b1;
          rd_col_reg  <= (rd_col_reg == COL_LAST) ? '0 : rd_col_reg + 1'b1;
        end
        if (busy && (lead_reg != LEAD_STOP)) lead_reg <= lead_reg + 1'b1;
        if (busy && (lead_reg == LEAD_ARM))  out_run_reg <= 1'b1;
        if (out_run_reg) begin
          if (out_cnt_reg == LAST_ADDR) out_run_reg <= 1'b0;
          else                          out_cnt_reg <= out_cnt_reg + 1'b1;
          if (out_col_reg == COL_LAST) begin
            out_col_reg <= '0;
            out_row_reg <= out_row_reg + 1'b1;
          end else begin
            out_col_reg <= out_col_reg + 1'b1;
          end
        end
      end
    end
  end

  assign rd_addr = rd_addr_reg;
  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

  // ---------------- Line buffer ----------------
  // One entry per column: {pixel two rows up, pixel one row up}. The read is
  // addressed by the column being requested from the image BRAM, so the
  // entry arrives together with the matching rd_data.
  logic [2*PIX_W-1:0] lb_mem [IMG_W];
  logic [2*PIX_W-1:0] lb_q_reg;

  always_ff @(posedge clk) begin
    lb_q_reg <= lb_mem[rd_col_reg];
    if (rd_vld_reg) lb_mem[lb_wcol_reg] <= {lb_q_reg[PIX_W-1:0], rd_data};
  end

  // ---------------- 3x3 window ----------------
  // col_n is the newest (right) column, taps_m the centre column and taps_l
  // the left column; index 0 is the top row.
  logic [PIX_W-1:0] col_n  [3];
  logic [PIX_W-1:0] taps_m [3];
  logic [PIX_W-1:0] taps_l [3];

  assign col_n[0] = lb_q_reg[2*PIX_W-1:PIX_W];
  assign col_n[1] = lb_q_reg[PIX_W-1:0];
  assign col_n[2] = rd_data;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win
      logic [PIX_W-1:0] m_reg;
      logic [PIX_W-1:0] l_reg;
      always_ff @(posedge clk) begin
        if (rd_vld_reg) begin
          m_reg <= col_n[gi];
          l_reg <= m_reg;
        end
      end
      assign taps_m[gi] = m_reg;
      assign taps_l[gi] = l_reg;
    end
  endgenerate

  // ---------------- Gradient and output pixel ----------------
  logic [GW-1:0] sum_r, sum_l, sum_t, sum_b;
  logic [GW-1:0] gx, gy, abs_x, abs_y, mag;

  always_comb begin
    sum_r = GW'(col_n[0]) + (GW'(col_n[1]) << 1) + GW'(col_n[2]);
    sum_l = GW'(taps_l[0]) + (GW'(taps_l[1]) << 1) + GW'(taps_l[2]);
    sum_t = GW'(taps_l[0]) + (GW'(taps_m[0]) << 1) + GW'(col_n[0]);
    sum_b = GW'(taps_l[2]) + (GW'(taps_m[2]) << 1) + GW'(col_n[2]);
    // Two's-complement differences; each sum is at most 4*(2^PIX_W-1).
    gx    = sum_r - sum_l;
    gy    = sum_t - sum_b;
    abs_x = gx[GW-1] ? (~gx + 1'b1) : gx;
    abs_y = gy[GW-1] ? (~gy + 1'b1) : gy;
    mag   = abs_x + abs_y;

    edge_hit = (mag >= thr_reg);
    border   = (out_row_reg == '0) || (out_row_reg == ROW_LAST) ||
               (out_col_reg == '0) || (out_col_reg == COL_LAST);

    pix_out = '1;
    if (!border) begin
      if (mode_reg) pix_out = (|mag[GW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
      else          pix_out = edge_hit ? '0 : '1;
    end
  end

`ifdef SOBEL_STATS_EN
  logic [ADDR_W:0] edge_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      edge_count_reg <= '0;
    else if (accept)
      edge_count_reg <= '0;
    else if (out_run_reg && !border && !mode_reg && edge_hit)
      edge_count_reg <= edge_count_reg + 1'b1;
  end

  assign edge_count = edge_count_reg;
`endif

endmodule

// File: tb/tb_sobel_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_sobel_stream_engine
//
// Directed bench for sobel_stream_engine on an 8x8 image with a 1-cycle
// BRAM model. Expected writes are produced by a direct 2D Sobel reference
// and queued at frame start; every DUT write pops and checks one entry.
// ---------------------------------------------------------------------------
module tb_sobel_stream_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int PW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [PW+2:0] threshold;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          busy;
  logic          done;
`ifdef SOBEL_STATS_EN
  logic [AW:0]   edge_count;
`endif

  sobel_stream_engine #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .RD_LAT(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .threshold (threshold),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
`ifdef SOBEL_STATS_EN
    ,
    .edge_count(edge_count)
`endif
  );

  always #5 clk = ~clk;

  // Input image BRAM, 1-cycle read latency.
  logic [PW-1:0] img [N];
  always @(posedge clk) rd_data <= img[rd_addr];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int base = 0;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    int addr;
    int data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Cycle index relative to the start-acceptance cycle (cycle 0).
  function automatic int cyc();
    return edge_cnt - base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int ref_pix(int j, bit m, int thr);
    int r, c, gx, gy, mag;
    int p[3][3];
    r = j / W;
    c = j % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 255;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        p[a][b] = int'(img[(r + a - 1) * W + (c + b - 1)]);
    gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy  = (p[0][0] + 2 * p[0][1] + p[0][2]) - (p[2][0] + 2 * p[2][1] + p[2][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m) return (mag > 255) ? 255 : mag;
    return (mag >= thr) ? 0 : 255;
  endfunction

  // Write monitor: one line per write transaction.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      chk("write_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        $display("wr cyc=%0d addr=%0d data=%0d exp_addr=%0d exp_data=%0d",
                 cyc(), wr_addr, wr_data, mon_e.addr, mon_e.data);
        chk("wr_addr", 32'(wr_addr), mon_e.addr);
        chk("wr_data", 32'(wr_data), mon_e.data);
        chk("wr_cycle", cyc(), mon_e.addr + W + 4);
      end
    end
    if (!rst && done) done_cnt++;
  end

  task automatic fill_flat(input int v);
    for (int i = 0; i < N; i++) img[i] = 8'(v);
  endtask

  task automatic fill_step(input int hi);
    for (int i = 0; i < N; i++) img[i] = ((i % W) >= 4) ? 8'(hi) : 8'd0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_exp(input bit m, input int thr);
    exp_t e;
    for (int j = 0; j < N; j++) begin
      e.addr = j;
      e.data = ref_pix(j, m, thr);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit m, input int thr);
    @(negedge clk);
    mode      = m;
    threshold = 11'(thr);
    start     = 1'b1;
    base      = edge_cnt;
    @(negedge clk);
    start     = 1'b0;
    // Scramble the inputs: the frame must use the values sampled at start.
    mode      = ~m;
    threshold = 11'($urandom_range(0, 2047));
  endtask

  // Full frame; a stray start pulse is applied in cycle 'stray' (-1 = none).
  task automatic run_frame(input bit m, input int thr, input int stray);
    int got;
    push_exp(m, thr);
    pulse_start(m, thr);
    $display("frame mode=%0d thr=%0d stray=%0d", m, thr, stray);
    chk("busy_c1", 32'(busy), 1);
    chk("rd_addr_c1", 32'(rd_addr), 0);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = (cyc() == stray);
      if (cyc() == N) chk("rd_addr_last", 32'(rd_addr), N - 1);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", got, 1);
    chk("done_cycle", cyc(), N + W + 4);
    chk("busy_at_done", 32'(busy), 0);
    chk("writes_left", exp_q.size(), 0);
    @(negedge clk);
    start = 1'b0;
    chk("done_width", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
    chk("rd_addr_hold", 32'(rd_addr), N - 1);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    threshold = '0;
    fill_flat(0);
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill_flat(100);
    run_frame(1'b0, 150, -1);

    fill_step(200);
    run_frame(1'b0, 150, -1);
`ifdef SOBEL_STATS_EN
    chk("edge_count", 32'(edge_count), 12);
    repeat (5) @(negedge clk);
    chk("edge_count_hold", 32'(edge_count), 12);
`endif
    run_frame(1'b1, 150, -1);

    fill_step(25);
    run_frame(1'b0, 100, -1);
    run_frame(1'b0, 101, -1);

    fill_rand();
    run_frame(1'b1, 0, -1);
    run_frame(1'b0, 300, -1);

    // Reset in cycle 30 of a frame.
    fill_step(200);
    push_exp(1'b0, 150);
    pulse_start(1'b0, 150);
    for (int i = 0; i < 100 && cyc() < 30; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_idle", 32'(busy), 0);

    // Full frame with a start pulse in cycle 40, then one in the DONE cycle.
    run_frame(1'b0, 150, 40);
    fill_rand();
    run_frame(1'b1, 0, N + W + 4);
    @(negedge clk);
    chk("done_start_ignored", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
